pmem_responder: RTL
===================

// Module: pmem_responder
// PURPOSE
//  Physical-memory side of the cache<->pmem line interface: accepts one 128-bit
//  line read or write per request, serves it from an internal line array after
//  a fixed latency, pulses pmem_resp. Sits below the cache as the synthesizable
//  main-memory model for simulation and FPGA bring-up.
// PARAMETERS
//  LATENCY     10  cycles from request acceptance to pmem_resp (legal >= 1)
//  INDEX_BITS  8   line array depth = 2**INDEX_BITS lines (16 B each)
// PORTS
//  clk           in   1    clock, all state on rising edge
//  rst_n         in   1    asynchronous, active-low reset
//  pmem_read     in   1    line read request, held until pmem_resp
//  pmem_write    in   1    line write request, held until pmem_resp
//  pmem_address  in   16   byte address (lc3b_word); [3:0] ignored
//  pmem_wdata    in   128  write line (mem_bus), word 0 in [15:0]
//  pmem_rdata    out  128  read line (mem_bus), valid while pmem_resp=1
//  pmem_resp     out  1    one-cycle completion pulse
//  pmem_err      out  1    sticky protocol-error flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, pmem_resp=0, pmem_rdata=0, counter=0,
//    pmem_err=0. Line array is NOT cleared. Reset mid-request aborts it; a
//    pending write is not committed.
//  - Index = pmem_address[INDEX_BITS+3:4]; higher address bits alias.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: if pmem_read|pmem_write, latch address, wdata, op; counter <= LATENCY-1;
//      go BUSY (if LATENCY==1 go directly RESP). Both asserted: write wins.
//    BUSY: decrement counter; at counter==1 go RESP.
//    RESP: pmem_resp=1 for exactly this cycle; read -> pmem_rdata = array[idx]
//      (registered, loaded on BUSY->RESP edge); write -> array[idx] <= wdata on
//      the RESP edge, pmem_rdata holds previous value. Always return to IDLE.
//  - Latency: request first seen high in IDLE at cycle 0 -> pmem_resp high at
//    cycle LATENCY. Back-to-back: new request may be seen in the cycle after
//    RESP (IDLE), i.e. min spacing LATENCY+1 cycles per transaction.
//  - Inputs are sampled only in IDLE; changes of address/data/op while BUSY or
//    RESP are ignored (latched values used). Request dropped before resp: the
//    transaction still completes and pulses pmem_resp.
//  - pmem_rdata retains its value outside RESP (no return to zero).
//  - Read after write to same line returns the written line.
// CONFIGURATION
//  PMEM_PROTOCOL_CHECK_EN defined: pmem_err set (sticky until reset) when
//    (a) pmem_read & pmem_write both high in any cycle, or (b) in BUSY, the
//    latched request drops or pmem_address[15:4] differs from the latched value.
//    Also emits $error in simulation.
//  Not defined: pmem_err tied 0; no checking logic; behaviour otherwise identical.
// TESTING
//  1. Write line 0x1111..8888 @0x0040, then read @0x004A -> resp at cycle 10
//     each; read returns identical 128-bit line.
//  2. LATENCY=1: read held from cycle 0 -> pmem_resp=1 at cycle 1 only, IDLE at 2.
//  3. Write-back then immediate read (write @0x0100, read @0x0200 asserted the
//     cycle after resp) -> second resp exactly LATENCY+1 cycles after first.
//  4. Assert rst_n=0 at cycle 5 of a write @0x0080 -> resp never pulses; later
//     read @0x0080 returns pre-write contents.
//  5. INDEX_BITS=8: write @0x1000, read @0x0000 -> same line (aliasing).
//  6. With PMEM_PROTOCOL_CHECK_EN: change address while BUSY -> pmem_err=1,
//     held until reset; transaction completes on original address. Without: pmem_err=0.

Source files
------------

// File: rtl/pmem_if.sv
// Cache <-> physical-memory line interface: one 128-bit line read or write per request.
// The master (cache) holds a request until it sees the one-cycle pmem_resp pulse.
interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_err
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency main-memory model serving 16-byte lines from an internal array.
// Optional protocol checker: define PMEM_PROTOCOL_CHECK_EN to drive a sticky pmem_err.
module pmem_responder #(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  pmem_if.slave  bus
);

  localparam int CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [127:0]            wdata_q;
  logic                    wr_q;
  logic                    resp_q;
  logic [127:0]            rdata_q;
  logic [127:0]            mem [DEPTH];

  logic [INDEX_BITS-1:0]   req_idx;
  logic                    req;
  logic                    unused_addr;

  assign req_idx     = bus.pmem_address[INDEX_BITS+3:4];
  assign req         = bus.pmem_read | bus.pmem_write;
  // Offset bits and aliased upper bits are not needed in the default build.
  assign unused_addr = ^bus.pmem_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            idx_q   <= req_idx;
            wdata_q <= bus.pmem_wdata;
            wr_q    <= bus.pmem_write;  // write wins when both are high
            cnt_q   <= CW'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              if (!bus.pmem_write) rdata_q <= mem[req_idx];
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            if (!wr_q) rdata_q <= mem[idx_q];
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Commit happens on the edge leaving RESP, so a reset earlier drops the write.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q) mem[idx_q] <= wdata_q;
  end

  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_resp  = resp_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [11:0] tag_q;
  logic        err_q;
  logic        viol;

  assign viol = (bus.pmem_read & bus.pmem_write) |
                ((state_q == BUSY) &&
                 ((wr_q ? !bus.pmem_write : !bus.pmem_read) ||
                  (bus.pmem_address[15:4] != tag_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) tag_q <= bus.pmem_address[15:4];
      if (viol) err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && viol) $error("pmem_responder: protocol violation");
  end
`endif

  assign bus.pmem_err = err_q;
`else
  assign bus.pmem_err = 1'b0;
`endif

endmodule
